// File: rtl/display7_pkg.sv
//------------------------------------------------------------------------------
// Module  : display7_pkg
// Purpose : Shared constants and helpers for the 7-segment scan driver.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package display7_pkg;

  // Active-high gfedcba patterns, entry k at bits [7k+6:7k], hex 0..F.
  localparam logic [16*7-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Bit k set when digit k is a leading zero; disabled digits read as zero.
  function automatic logic [15:0] lzb_mask(input logic [63:0] nibbles,
                                           input logic [15:0] en,
                                           input int          digits);
    logic [15:0] mask;
    logic        higher_zero;
    logic        is_zero;
    mask        = '0;
    higher_zero = 1'b1;
    for (int k = 15; k >= 1; k--) begin
      if (k < digits) begin
        is_zero     = !en[k] || (nibbles[4*k +: 4] == 4'h0);
        mask[k]     = higher_zero && is_zero;
        higher_zero = higher_zero && is_zero;
      end
    end
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
//------------------------------------------------------------------------------
// Module  : seg7_hex_decode
// Purpose : Combinational hex nibble to active-low 7-segment pattern.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_hex_decode
  import display7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = ~SEG_TABLE[7*nib_i +: 7];
  end

endmodule

`default_nettype wire

// File: rtl/display7_scan.sv
//------------------------------------------------------------------------------
// Module  : display7_scan
// Purpose : Time-multiplexed common-anode 7-segment scanner with LZB.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module display7_scan
  import display7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int BLANK  = 16
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iDp,
  input  logic [DIGITS-1:0]     iEn,
  input  logic                  iLzb,
  output logic [6:0]            oSeg,
  output logic                  oDp,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  first_q;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_sh_q;
  logic [DIGITS-1:0]     en_q;
  logic                  lzb_q;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;

  logic                  w_wrap;
  logic                  w_snap;
  logic                  w_dark;
  logic [3:0]            w_nib;
  logic [6:0]            w_dec_seg;
  logic [DIGITS-1:0]     w_lzb_mask;

  seg7_hex_decode u_dec (
    .nib_i (w_nib),
    .seg_o (w_dec_seg)
  );

  always_comb begin
    w_wrap = (cnt_q == CNT_LAST);
    cnt_d  = w_wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (w_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Shadows reload only at frame end so a frame is never torn.
    w_snap = first_q || (w_wrap && (idx_q == IDX_LAST));
  end

  always_comb begin
    w_nib      = data_q[4*idx_q +: 4];
    w_lzb_mask = DIGITS'(lzb_mask(64'(data_q), 16'(en_q), DIGITS));
    w_dark     = !en_q[idx_q] || (cnt_q < CNT_BLANK) || (lzb_q && w_lzb_mask[idx_q]);
    an_d       = w_dark ? '1 : ~(DIGITS'(1) << idx_q);
    seg_d      = w_dark ? SEG_OFF : w_dec_seg;
    dp_d       = w_dark ? 1'b1 : ~dp_sh_q[idx_q];
    frame_d    = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      data_q  <= '0;
      dp_sh_q <= '0;
      en_q    <= '0;
      lzb_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      if (w_snap) begin
        data_q  <= iData;
        dp_sh_q <= iDp;
        en_q    <= iEn;
        lzb_q   <= iLzb;
      end
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign oAn    = an_q;
  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oFrame = frame_q;

endmodule

`default_nettype wire
